load_store_unit: RTL and testbench

- Sits directly downstream of the instruction decoder in the execute stage.
- Consumes the decoder's memory controls (address valid, write enable, effective address, byte mask, sign-extend) plus rs2 store data.
- Runs one data-bus transaction per accepted request over a ready-handshaked word bus.
- Returns the aligned, masked, extended load result for register-file write-back, with done/error status to the core control FSM.

---
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Word data-bus between the load/store unit (master) and memory (slave).
// Ready-handshaked: the master holds its request until the slave asserts mem_ready_i.
interface load_store_unit_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one aligned word-bus beat per decoded memory request, with load extraction.
// Latency 2 cycles minimum (start -> req -> done), plus bus wait states; aborts after TIMEOUT waits.
// Backpressure: holds the bus request until mem_ready_i; new starts are ignored until IDLE.
// Option LSU_MISALIGN_TRAP_EN: misaligned half/word requests complete with err_o, no bus cycle.
module load_store_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    input  logic                    addr_valid_i,
    input  logic                    d_we_i,
    input  logic [31:0]             addr_i,
    input  logic [3:0]              mask_i,
    input  logic                    sext_i,
    input  logic [31:0]             wdata_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [31:0]             load_data_o,
    load_store_unit_if.master       bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q, sext_q, err_q;
    logic [29:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [1:0]       size_q;     // 0 byte, 1 half, 2 word
    logic [1:0]       off_q;
    logic [31:0]      load_q;

    logic             accept, trap, capture, abort;

    // Request decode at acceptance
    logic             is_word, is_half;
    logic [1:0]       off_eff;
    logic [7:0]       be_wide;
    logic [31:0]      wdata_lane;
    logic [1:0]       size_d;

    assign is_word = mask_i[3];
    assign is_half = mask_i[1] & ~mask_i[3];
    assign size_d  = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    // Without the trap, misaligned accesses are pulled back to natural alignment.
    assign off_eff = is_word ? 2'b00 : (is_half ? {addr_i[1], 1'b0} : addr_i[1:0]);
    assign be_wide = {4'b0000, mask_i} << off_eff;

    always_comb begin
        wdata_lane = wdata_i;
        if (is_half)
            wdata_lane = {2{wdata_i[15:0]}};
        else if (!is_word)
            wdata_lane = {4{wdata_i[7:0]}};
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
`endif

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        trap    = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && addr_valid_i) begin
                    accept  = 1'b1;
                    state_d = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misalign) begin
                        trap    = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            REQ: begin
                if (bus.mem_ready_i) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load extraction from the returned word
    logic [31:0] shifted, load_ext;
    assign shifted = bus.mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    load_ext = {{24{sext_q & shifted[7]}},  shifted[7:0]};
            2'd1:    load_ext = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            load_q  <= '0;
        end else begin
            if (accept) begin
                cnt_q   <= '0;
                we_q    <= d_we_i;
                sext_q  <= sext_i;
                err_q   <= trap;
                addr_q  <= addr_i[31:2];
                be_q    <= be_wide[3:0];
                wdata_q <= d_we_i ? wdata_lane : 32'd0;
                size_q  <= size_d;
                off_q   <= off_eff;
            end
            if (state_q == REQ && !capture && !abort)
                cnt_q <= cnt_q + 1'b1;
            if (abort)
                err_q <= 1'b1;
            if (capture && !we_q)
                load_q <= load_ext;
        end
    end

    logic in_req;
    assign in_req = (state_q == REQ);

    assign busy_o      = in_req;
    assign done_o      = (state_q == DONE);
    assign err_o       = done_o & err_q;
    assign load_data_o = load_q;

    assign bus.mem_req_o   = in_req;
    assign bus.mem_we_o    = in_req & we_q;
    assign bus.mem_addr_o  = in_req ? {addr_q, 2'b00} : 32'd0;
    assign bus.mem_be_o    = in_req ? be_q : 4'd0;
    assign bus.mem_wdata_o = in_req ? wdata_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed test of load_store_unit with TIMEOUT=4; inputs driven and outputs sampled on the falling edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0, addr_valid_i = 1'b0, d_we_i = 1'b0, sext_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [3:0]  mask_i = '0;
    logic        busy_o, done_o, err_o;
    logic [31:0] load_data_o;

    load_store_unit_if bus_if();

    load_store_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .start_i      (start_i),
        .addr_valid_i (addr_valid_i),
        .d_we_i       (d_we_i),
        .addr_i       (addr_i),
        .mask_i       (mask_i),
        .sext_i       (sext_i),
        .wdata_i      (wdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .load_data_o  (load_data_o),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Pulses a request for one cycle; returns at the falling edge of the following cycle.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                         input logic sext, input logic [31:0] wdata);
        start_i = 1'b1; addr_valid_i = 1'b1; d_we_i = we;
        addr_i = addr; mask_i = mask; sext_i = sext; wdata_i = wdata;
        @(negedge clk);
        start_i = 1'b0; addr_valid_i = 1'b0;
    endtask

    // Answers the outstanding beat this cycle; returns at the falling edge of the DONE cycle.
    task automatic respond(input logic [31:0] rdata);
        bus_if.mem_ready_i = 1'b1;
        bus_if.mem_rdata_i = rdata;
        @(negedge clk);
        bus_if.mem_ready_i = 1'b0;
        bus_if.mem_rdata_i = 32'd0;
    endtask

    int cnt;
    logic seen;

    initial begin
        bus_if.mem_ready_i = 1'b0;
        bus_if.mem_rdata_i = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_req",  {31'd0, bus_if.mem_req_o}, 32'd0);
        check("rst_load", load_data_o, 32'd0);
        reset_n_i = 1'b1;
        @(negedge clk);

        // start without addr_valid is ignored; ready outside REQ is ignored
        start_i = 1'b1; bus_if.mem_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; bus_if.mem_ready_i = 1'b0;
        check("novalid_busy", {31'd0, busy_o}, 32'd0);
        check("novalid_done", {31'd0, done_o}, 32'd0);

        // SW 0x1004
        issue(1'b1, 32'h0000_1004, 4'b1111, 1'b0, 32'hDEAD_BEEF);
        check("sw_req",   {31'd0, bus_if.mem_req_o}, 32'd1);
        check("sw_busy",  {31'd0, busy_o}, 32'd1);
        check("sw_we",    {31'd0, bus_if.mem_we_o}, 32'd1);
        check("sw_addr",  bus_if.mem_addr_o, 32'h0000_1004);
        check("sw_be",    {28'd0, bus_if.mem_be_o}, 32'hF);
        check("sw_wdata", bus_if.mem_wdata_o, 32'hDEAD_BEEF);
        respond(32'd0);
        check("sw_done",  {31'd0, done_o}, 32'd1);
        check("sw_err",   {31'd0, err_o}, 32'd0);
        check("sw_busy0", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        check("sw_done_pulse", {31'd0, done_o}, 32'd0);

        // SB 0x2003
        issue(1'b1, 32'h0000_2003, 4'b0001, 1'b0, 32'h0000_00A5);
        check("sb_addr",  bus_if.mem_addr_o, 32'h0000_2000);
        check("sb_be",    {28'd0, bus_if.mem_be_o}, 32'h8);
        check("sb_wdata", bus_if.mem_wdata_o, 32'hA5A5_A5A5);
        respond(32'd0);
        check("sb_done",  {31'd0, done_o}, 32'd1);
        @(negedge clk);

        // LB / LBU 0x3002
        issue(1'b0, 32'h0000_3002, 4'b0001, 1'b1, 32'hFFFF_FFFF);
        check("lb_we",    {31'd0, bus_if.mem_we_o}, 32'd0);
        check("lb_be",    {28'd0, bus_if.mem_be_o}, 32'h4);
        check("lb_wdata", bus_if.mem_wdata_o, 32'd0);
        respond(32'h12F0_3456);
        check("lb_data",  load_data_o, 32'hFFFF_FFF0);
        @(negedge clk);
        issue(1'b0, 32'h0000_3002, 4'b0001, 1'b0, 32'd0);
        respond(32'h12F0_3456);
        check("lbu_data", load_data_o, 32'h0000_00F0);
        @(negedge clk);

        // LHU 0x3002 with three wait states
        issue(1'b0, 32'h0000_3002, 4'b0011, 1'b0, 32'd0);
        check("lhu_be", {28'd0, bus_if.mem_be_o}, 32'hC);
        cnt = 0;
        repeat (3) begin
            cnt += int'(busy_o);
            @(negedge clk);
        end
        cnt += int'(busy_o);
        respond(32'h8001_ABCD);
        check("lhu_busy_cycles", cnt, 32'd4);
        check("lhu_done", {31'd0, done_o}, 32'd1);
        check("lhu_data", load_data_o, 32'h0000_8001);
        @(negedge clk);

        // LH same address, sign-extended
        issue(1'b0, 32'h0000_3002, 4'b0011, 1'b1, 32'd0);
        respond(32'h8001_ABCD);
        check("lh_data", load_data_o, 32'hFFFF_8001);
        @(negedge clk);

        // Store leaves load_data untouched
        issue(1'b1, 32'h0000_1000, 4'b1111, 1'b0, 32'h1234_5678);
        respond(32'h5555_5555);
        check("st_keep_load", load_data_o, 32'hFFFF_8001);
        @(negedge clk);

        // Timeout with ready held low
        issue(1'b0, 32'h0000_5000, 4'b1111, 1'b0, 32'd0);
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            cnt += int'(bus_if.mem_req_o);
            @(negedge clk);
        end
        check("to_seen_done", {31'd0, seen}, 32'd1);
        check("to_req_cycles", cnt, 32'd4);
        check("to_err", {31'd0, err_o}, 32'd1);
        check("to_keep_load", load_data_o, 32'hFFFF_8001);
        @(negedge clk);
        check("to_idle_busy", {31'd0, busy_o}, 32'd0);
        check("to_idle_req",  {31'd0, bus_if.mem_req_o}, 32'd0);
        check("to_idle_done", {31'd0, done_o}, 32'd0);

        // Misaligned LW 0x4002
        issue(1'b0, 32'h0000_4002, 4'b1111, 1'b0, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_req",  {31'd0, bus_if.mem_req_o}, 32'd0);
        check("mis_done", {31'd0, done_o}, 32'd1);
        check("mis_err",  {31'd0, err_o}, 32'd1);
        check("mis_load", load_data_o, 32'hFFFF_8001);
`else
        check("mis_req",  {31'd0, bus_if.mem_req_o}, 32'd1);
        check("mis_addr", bus_if.mem_addr_o, 32'h0000_4000);
        check("mis_be",   {28'd0, bus_if.mem_be_o}, 32'hF);
        respond(32'hCAFE_F00D);
        check("mis_done", {31'd0, done_o}, 32'd1);
        check("mis_err",  {31'd0, err_o}, 32'd0);
        check("mis_load", load_data_o, 32'hCAFE_F00D);
`endif
        @(negedge clk);

        // Reset pulsed mid-REQ
        issue(1'b0, 32'h0000_6000, 4'b1111, 1'b0, 32'd0);
        check("rq_req", {31'd0, bus_if.mem_req_o}, 32'd1);
        reset_n_i = 1'b0;
        #1;
        check("rq_req_drop", {31'd0, bus_if.mem_req_o}, 32'd0);
        check("rq_busy",     {31'd0, busy_o}, 32'd0);
        check("rq_load",     load_data_o, 32'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            seen |= done_o;
            @(negedge clk);
        end
        check("rq_no_done", {31'd0, seen}, 32'd0);
        check("rq_idle",    {31'd0, busy_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
